// File: rtl/collision_pkg.sv
`default_nettype none
// ============================================================================
// Module      : collision_pkg
// Description : Shared default constants and coordinate type for the Pong
//               collision-detection block.
// Revision    : 1.0 - initial release
// ============================================================================
package collision_pkg;

    localparam int COORD_W   = 10;
    localparam int BALL_R    = 5;
    localparam int PADDLE_R  = 20;
    localparam int FLOOR_ROW = 479;

    typedef logic [COORD_W-1:0] coord_t;

endpackage : collision_pkg
`default_nettype wire

// File: rtl/edge_pulse.sv
`default_nettype none
// ============================================================================
// Module      : edge_pulse
// Description : Registers a level and emits a one-cycle pulse in the same
//               cycle the registered level first rises.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_pulse
    import collision_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic levelQ,
    output logic pulse
);

    logic r_level;
    logic r_pulse;

    // The pulse is registered alongside the level, so both appear after the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_level <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_level <= level;
            r_pulse <= level & ~r_level;
        end
    end

    assign levelQ = r_level;
    assign pulse  = r_pulse;

endmodule : edge_pulse
`default_nettype wire

// File: rtl/collision_detection.sv
`default_nettype none
// ============================================================================
// Module      : collision_detection
// Description : Flags ball-on-paddle and ball-on-floor contact with registered
//               levels and rising-edge pulses. COLLISION_BBOX_EN widens the
//               X test to |ballX-paddleX| <= BALL_RADIUS.
// Revision    : 1.0 - initial release
// ============================================================================
module collision_detection
    import collision_pkg::*;
#(
    parameter int BIT_WIDTH     = COORD_W,
    parameter int BALL_RADIUS   = BALL_R,
    parameter int PADDLE_RADIUS = PADDLE_R,
    parameter int FLOOR_Y       = FLOOR_ROW
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BIT_WIDTH-1:0] paddleX,
    input  logic [BIT_WIDTH-1:0] paddleY,
    input  logic [BIT_WIDTH-1:0] ballX,
    input  logic [BIT_WIDTH-1:0] ballY,
    output logic                 ballTouchingPaddle,
    output logic                 ballTouchingFloor,
    output logic                 paddleHit,
    output logic                 floorHit
);

    // Two guard bits keep every sum and difference below free of wrap-around.
    localparam int EXT_W = BIT_WIDTH + 2;

    localparam logic [EXT_W-1:0] c_ballR   = EXT_W'(BALL_RADIUS);
    localparam logic [EXT_W-1:0] c_paddleR = EXT_W'(PADDLE_RADIUS);
    localparam logic [EXT_W-1:0] c_floorY  = EXT_W'(FLOOR_Y);

    logic [EXT_W-1:0] w_paddleX;
    logic [EXT_W-1:0] w_paddleY;
    logic [EXT_W-1:0] w_ballX;
    logic [EXT_W-1:0] w_ballY;
    logic [EXT_W-1:0] w_lowBound;
    logic [EXT_W-1:0] w_highBound;
    logic             w_inXRange;
    logic             w_inYRange;
    logic             w_paddleContact;
    logic             w_floorContact;

    assign w_paddleX = EXT_W'(paddleX);
    assign w_paddleY = EXT_W'(paddleY);
    assign w_ballX   = EXT_W'(ballX);
    assign w_ballY   = EXT_W'(ballY);

    // Paddles near the top edge clamp the lower bound to row 0.
    assign w_lowBound  = (w_paddleY < c_paddleR) ? '0 : (w_paddleY - c_paddleR);
    assign w_highBound = w_paddleY + c_paddleR;
    assign w_inYRange  = (w_ballY >= w_lowBound) && (w_ballY <= w_highBound);

`ifdef COLLISION_BBOX_EN
    logic [EXT_W-1:0] w_xDist;
    assign w_xDist    = (w_ballX >= w_paddleX) ? (w_ballX - w_paddleX)
                                               : (w_paddleX - w_ballX);
    assign w_inXRange = (w_xDist <= c_ballR);
`else
    assign w_inXRange = (w_ballX == w_paddleX);
`endif

    assign w_paddleContact = w_inXRange && w_inYRange;
    assign w_floorContact  = (w_ballY >= c_ballR) && ((w_ballY - c_ballR) == c_floorY);

    edge_pulse u_paddleEdge (
        .clk    (clk),
        .reset  (reset),
        .level  (w_paddleContact),
        .levelQ (ballTouchingPaddle),
        .pulse  (paddleHit)
    );

    edge_pulse u_floorEdge (
        .clk    (clk),
        .reset  (reset),
        .level  (w_floorContact),
        .levelQ (ballTouchingFloor),
        .pulse  (floorHit)
    );

endmodule : collision_detection
`default_nettype wire

// File: tb/tb_collision_detection.sv
`default_nettype none
// ============================================================================
// Module      : tb_collision_detection
// Description : Randomized scoreboard bench for collision_detection; the
//               reference model follows COLLISION_BBOX_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_collision_detection;
    import collision_pkg::*;

    logic   clk = 1'b0;
    logic   reset;
    coord_t paddleX, paddleY, ballX, ballY;
    logic   ballTouchingPaddle, ballTouchingFloor, paddleHit, floorHit;

    int checks = 0;
    int errors = 0;
    int cycleIdx = 0;

    // Expected {touchPaddle, touchFloor, paddleHit, floorHit} per sampled edge.
    logic [3:0] sbQueue[$];
    bit   prevP = 1'b0;
    bit   prevF = 1'b0;

    collision_detection dut (
        .clk                (clk),
        .reset              (reset),
        .paddleX            (paddleX),
        .paddleY            (paddleY),
        .ballX              (ballX),
        .ballY              (ballY),
        .ballTouchingPaddle (ballTouchingPaddle),
        .ballTouchingFloor  (ballTouchingFloor),
        .paddleHit          (paddleHit),
        .floorHit           (floorHit)
    );

    always #5 clk = ~clk;

    // Reference rules evaluated with plain integers, where nothing can wrap.
    function automatic bit modelPaddle(int px, int py, int bx, int by);
        int lo;
        bit xOk;
        lo = py - PADDLE_R;
        if (lo < 0) lo = 0;
`ifdef COLLISION_BBOX_EN
        xOk = ((bx - px) <= BALL_R) && ((px - bx) <= BALL_R);
`else
        xOk = (bx == px);
`endif
        return xOk && (by >= lo) && (by <= py + PADDLE_R);
    endfunction

    function automatic bit modelFloor(int by);
        return (by - BALL_R) == FLOOR_ROW;
    endfunction

    task automatic applyCycle(input bit rst, input int px, input int py,
                              input int bx, input int by);
        bit tp, tf, ph, fh;
        @(negedge clk);
        reset   = rst;
        paddleX = coord_t'(px);
        paddleY = coord_t'(py);
        ballX   = coord_t'(bx);
        ballY   = coord_t'(by);
        if (rst) begin
            tp = 0; tf = 0; ph = 0; fh = 0;
        end else begin
            tp = modelPaddle(int'(paddleX), int'(paddleY), int'(ballX), int'(ballY));
            tf = modelFloor(int'(ballY));
            ph = tp && !prevP;
            fh = tf && !prevF;
        end
        prevP = tp;
        prevF = tf;
        sbQueue.push_back({tp, tf, ph, fh});
    endtask

    task automatic compareBit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %b expected %b (paddle %0d,%0d ball %0d,%0d)",
                     name, cycleIdx, got, exp, paddleX, paddleY, ballX, ballY);
        end
    endtask

    // Monitor: every sampled edge has a pending expectation to pop.
    initial begin
        logic [3:0] exp;
        forever begin
            @(posedge clk);
            #1;
            if (sbQueue.size() != 0) begin
                exp = sbQueue.pop_front();
                compareBit("ballTouchingPaddle", ballTouchingPaddle, exp[3]);
                compareBit("ballTouchingFloor",  ballTouchingFloor,  exp[2]);
                compareBit("paddleHit",          paddleHit,          exp[1]);
                compareBit("floorHit",           floorHit,           exp[0]);
                cycleIdx++;
            end
        end
    end

    initial begin
        int px, py, bx, by, sel;
        reset = 1'b1;
        paddleX = 10'd50; paddleY = 10'd240; ballX = 10'd100; ballY = 10'd200;

        applyCycle(1, 50, 240, 100, 200);
        applyCycle(1, 50, 240, 100, 200);
        applyCycle(0, 50, 240, 100, 200);
        applyCycle(0, 50, 240, 100, 200);
        // Continuous paddle contact across the Y span: one pulse only.
        applyCycle(0, 50, 240, 50, 240);
        applyCycle(0, 50, 240, 50, 260);
        applyCycle(0, 50, 240, 50, 220);
        applyCycle(0, 50, 240, 51, 240);
        applyCycle(0, 50, 240, 50, 261);
        applyCycle(0, 50, 240, 50, 219);
        applyCycle(0, 50, 240, 100, 200);
        // Floor boundary.
        applyCycle(0, 50, 240, 200, 484);
        applyCycle(0, 50, 240, 200, 484);
        applyCycle(0, 50, 240, 200, 484);
        applyCycle(0, 50, 240, 200, 483);
        applyCycle(0, 50, 240, 200, 485);
        // Simultaneous contact, then reset mid-contact.
        applyCycle(0, 50, 479, 50, 484);
        applyCycle(0, 50, 479, 50, 484);
        applyCycle(1, 50, 479, 50, 484);
        applyCycle(0, 50, 479, 50, 484);
        applyCycle(0, 50, 479, 50, 484);
        // Clamped lower bound and floor underflow.
        applyCycle(0, 50, 10, 100, 100);
        applyCycle(0, 50, 10, 50, 0);
        applyCycle(0, 50, 10, 0, 3);
        applyCycle(0, 1023, 1023, 1023, 1023);

        px = 300; py = 240; bx = 0; by = 0;
        for (int i = 0; i < 600; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel >= 7) begin
                // Hold the previous coordinates to exercise sustained contact.
            end else begin
                px = int'($urandom_range(0, 1023));
                py = (sel == 0) ? int'($urandom_range(0, 25)) : int'($urandom_range(0, 1023));
                case ($urandom_range(0, 4))
                    0, 1:    bx = px;
                    2:       bx = px + int'($urandom_range(0, 12)) - 6;
                    default: bx = int'($urandom_range(0, 1023));
                endcase
                if (bx < 0) bx = 0;
                if (bx > 1023) bx = 1023;
                case ($urandom_range(0, 3))
                    0:       by = 484 + int'($urandom_range(0, 2)) - 1;
                    1:       by = int'($urandom_range(0, 1023));
                    default: by = py + int'($urandom_range(0, 46)) - 23;
                endcase
                if (by < 0) by = 0;
                if (by > 1023) by = 1023;
            end
            applyCycle(($urandom_range(0, 49) == 0), px, py, bx, by);
        end

        repeat (3) @(negedge clk);
        if (sbQueue.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", sbQueue.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_collision_detection
`default_nettype wire
